// File: rtl/vehicle_det_pkg.sv
// -----------------------------------------------------------------------------
// vehicle_det_pkg
//   Shared types and default constants for the country-road vehicle detector.
//   - vdet_state_t      : detector FSM state (2-bit encoding)
//   - VDET_DEBOUNCE_DEF : default number of qualifying samples
//   - VDET_WAIT_W_DEF   : default width of the wait counter
//   - VDET_STARVE_DEF   : default starvation threshold in wait cycles
// -----------------------------------------------------------------------------
package vehicle_det_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    REQUEST = 2'd2,
    SERVED  = 2'd3
  } vdet_state_t;

  localparam int VDET_DEBOUNCE_DEF = 4;
  localparam int VDET_WAIT_W_DEF   = 16;
  localparam int VDET_STARVE_DEF   = 1000;

endpackage : vehicle_det_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Generic two-flop synchroniser for bringing asynchronous level signals into
//   the clk domain. Both stages clear on synchronous active-low reset.
//   Ports:
//     clk     - destination clock, rising edge
//     reset_n - synchronous active-low reset
//     d       - asynchronous input (WIDTH bits)
//     q       - synchronised output, two clk edges after d settles
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First stage may go metastable; the second stage gives it a full cycle to
  // resolve before anything downstream looks at the value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule : sync_2ff

// File: rtl/vehicle_detector.sv
// -----------------------------------------------------------------------------
// vehicle_detector
//   Front end for the highway/country traffic controller. Synchronises and
//   debounces the country-road loop sensor, then latches a request until the
//   controller acknowledges it by showing country green.
//
//   Optional feature macro: VEHICLE_DET_STARVE_EN
//     defined   -> adds the 'starve' output, set once a request has waited
//                  STARVE_LIMIT cycles, cleared when REQUEST is left
//     undefined -> no 'starve' port and no comparator
//
//   Parameters:
//     DEBOUNCE_CYCLES - consecutive high samples needed to qualify (2..255)
//     WAIT_W          - width of wait_count
//     STARVE_LIMIT    - starvation threshold, must be < 2**WAIT_W
//   Ports:
//     clk        - system clock, rising edge
//     reset_n    - synchronous active-low reset
//     sys_en     - system enable, 0 forces idle and clears counters
//     loop_raw   - asynchronous raw loop sensor, 1 = metal present
//     gc         - controller green-country, used as acknowledge
//     rc         - controller red-country
//     vehicle    - registered request to the controller
//     waiting    - 1 while in REQUEST
//     wait_count - cycles spent in the current or most recent REQUEST
//     starve     - starvation flag (only with VEHICLE_DET_STARVE_EN)
// -----------------------------------------------------------------------------
module vehicle_detector
  import vehicle_det_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = VDET_DEBOUNCE_DEF,
  parameter int WAIT_W          = VDET_WAIT_W_DEF,
  parameter int STARVE_LIMIT    = VDET_STARVE_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sys_en,
  input  logic              loop_raw,
  input  logic              gc,
  input  logic              rc,
  output logic              vehicle,
  output logic              waiting,
  output logic [WAIT_W-1:0] wait_count
`ifdef VEHICLE_DET_STARVE_EN
  ,
  output logic              starve
`endif
);

  localparam logic [7:0]        DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};

  logic              loop_s;

  vdet_state_t       state_q, state_d;
  logic [7:0]        db_cnt_q, db_cnt_d;
  logic [WAIT_W-1:0] wait_count_q, wait_count_d;
  logic              vehicle_q, vehicle_d;
  logic              waiting_q, waiting_d;

  sync_2ff #(
    .WIDTH (1)
  ) u_loop_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (loop_raw),
    .q       (loop_s)
  );

  // Next-state logic. sys_en low overrides everything, including a gc that
  // arrives on the same edge. wait_count counts every cycle spent in REQUEST,
  // so the edge that leaves REQUEST still adds the final cycle.
  always_comb begin
    state_d      = state_q;
    db_cnt_d     = db_cnt_q;
    wait_count_d = wait_count_q;

    if (!sys_en) begin
      state_d      = IDLE;
      db_cnt_d     = '0;
      wait_count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (loop_s) begin
            state_d  = QUALIFY;
            db_cnt_d = 8'd1;
          end
        end
        QUALIFY: begin
          if (!loop_s) begin
            state_d  = IDLE;
            db_cnt_d = '0;
          end else if (db_cnt_q == DB_LAST) begin
            state_d      = REQUEST;
            db_cnt_d     = '0;
            wait_count_d = '0;
          end else begin
            db_cnt_d = db_cnt_q + 8'd1;
          end
        end
        REQUEST: begin
          if (wait_count_q != WAIT_MAX) begin
            wait_count_d = wait_count_q + 1'b1;
          end
          if (gc) begin
            state_d = SERVED;
          end
        end
        SERVED: begin
          // Wait for the controller to hand the road back before re-arming,
          // so a car still sitting on the loop re-qualifies from scratch.
          if (!gc && rc) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    vehicle_d = (state_d == REQUEST);
    waiting_d = (state_d == REQUEST);
  end

`ifdef VEHICLE_DET_STARVE_EN
  localparam logic [WAIT_W-1:0] STARVE_LIM_W = WAIT_W'(STARVE_LIMIT);

  logic starve_q, starve_d;

  // Saturation keeps wait_count at or above the limit, so the flag holds for
  // the rest of the request and drops as soon as REQUEST is left.
  always_comb begin
    starve_d = (state_d == REQUEST) && (wait_count_d >= STARVE_LIM_W);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign starve = starve_q;
`else
  localparam int unused_starve_limit = STARVE_LIMIT;
`endif

  // Detector FSM and its registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      db_cnt_q     <= '0;
      wait_count_q <= '0;
      vehicle_q    <= 1'b0;
      waiting_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      db_cnt_q     <= db_cnt_d;
      wait_count_q <= wait_count_d;
      vehicle_q    <= vehicle_d;
      waiting_q    <= waiting_d;
    end
  end

  assign vehicle    = vehicle_q;
  assign waiting    = waiting_q;
  assign wait_count = wait_count_q;

endmodule : vehicle_detector

// File: tb/tb_vehicle_detector.sv
// -----------------------------------------------------------------------------
// tb_vehicle_detector
//   Directed bench for vehicle_detector with DEBOUNCE_CYCLES=4, WAIT_W=4 and
//   STARVE_LIMIT=10. Expected values are hand-derived edge by edge; the
//   starve flag is only checked when VEHICLE_DET_STARVE_EN is defined.
// -----------------------------------------------------------------------------
module tb_vehicle_detector;

  logic       clk;
  logic       reset_n;
  logic       sys_en;
  logic       loop_raw;
  logic       gc;
  logic       rc;
  logic       vehicle;
  logic       waiting;
  logic [3:0] wait_count;
  logic       starve;

  int n_checks = 0;
  int n_fail   = 0;

  vehicle_detector #(
    .DEBOUNCE_CYCLES (4),
    .WAIT_W          (4),
    .STARVE_LIMIT    (10)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sys_en     (sys_en),
    .loop_raw   (loop_raw),
    .gc         (gc),
    .rc         (rc),
    .vehicle    (vehicle),
    .waiting    (waiting),
    .wait_count (wait_count)
`ifdef VEHICLE_DET_STARVE_EN
    ,
    .starve     (starve)
`endif
  );

`ifndef VEHICLE_DET_STARVE_EN
  assign starve = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst_n_v, input logic en_v,
                               input logic loop_v, input logic gc_v,
                               input logic rc_v);
    reset_n  = rst_n_v;
    sys_en   = en_v;
    loop_raw = loop_v;
    gc       = gc_v;
    rc       = rc_v;
  endtask

  task automatic checkOutput(input string tag, input logic exp_vehicle,
                             input logic exp_waiting, input logic [3:0] exp_wc,
                             input logic exp_starve);
    n_checks++;
    assert (vehicle === exp_vehicle) else begin
      n_fail++;
      $error("[TB] FAIL %s vehicle observed=%0b expected=%0b", tag, vehicle, exp_vehicle);
    end
    n_checks++;
    assert (waiting === exp_waiting) else begin
      n_fail++;
      $error("[TB] FAIL %s waiting observed=%0b expected=%0b", tag, waiting, exp_waiting);
    end
    n_checks++;
    assert (wait_count === exp_wc) else begin
      n_fail++;
      $error("[TB] FAIL %s wait_count observed=%0d expected=%0d", tag, wait_count, exp_wc);
    end
`ifdef VEHICLE_DET_STARVE_EN
    n_checks++;
    assert (starve === exp_starve) else begin
      n_fail++;
      $error("[TB] FAIL %s starve observed=%0b expected=%0b", tag, starve, exp_starve);
    end
`else
    if (exp_starve !== 1'b0 && exp_starve !== 1'b1) begin
      $display("[TB] note: %s has undefined starve expectation", tag);
    end
`endif
  endtask

  initial begin
    $display("[TB] vehicle_detector directed test start");

    // Reset
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(2);
    checkOutput("reset", 1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1);
    checkOutput("post_reset", 1'b0, 1'b0, 4'd0, 1'b0);

    // Clean arrival: loop_s high after edge 2, request on edge 6
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(5);
    checkOutput("arrive_e5", 1'b0, 1'b0, 4'd0, 1'b0);
    step(1);
    checkOutput("arrive_e6", 1'b1, 1'b1, 4'd0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step(1);
      checkOutput("count", 1'b1, 1'b1, 4'(i), 1'b0);
    end

    // Acknowledge: gc for 5 cycles, the exit edge adds the last REQUEST cycle
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1);
    checkOutput("ack_first", 1'b0, 1'b0, 4'd4, 1'b0);
    step(4);
    checkOutput("ack_hold", 1'b0, 1'b0, 4'd4, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1);
    checkOutput("served_idle", 1'b0, 1'b0, 4'd4, 1'b0);
    step(3);
    checkOutput("requal_e4", 1'b0, 1'b0, 4'd4, 1'b0);
    step(1);
    checkOutput("requal_e5", 1'b1, 1'b1, 4'd0, 1'b0);

    // Sensor dropout: request stays latched
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(4);
    checkOutput("dropout", 1'b1, 1'b1, 4'd4, 1'b0);

    // Disable on the same edge as gc: disable wins, counters cleared
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1);
    checkOutput("disable_gc", 1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1);
    checkOutput("reenable", 1'b0, 1'b0, 4'd0, 1'b0);

    // Glitch: three-cycle high run must not request
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(3);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1);
      checkOutput("glitch", 1'b0, 1'b0, 4'd0, 1'b0);
    end

    // Reset mid-QUALIFY, then full latency again from a cleared synchroniser
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(4);
    checkOutput("qualify", 1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1);
    checkOutput("reset_qualify", 1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(5);
    checkOutput("rearrive_e5", 1'b0, 1'b0, 4'd0, 1'b0);
    step(1);
    checkOutput("rearrive_e6", 1'b1, 1'b1, 4'd0, 1'b0);

    // Starvation threshold and wait_count saturation
    step(9);
    checkOutput("wait_9", 1'b1, 1'b1, 4'd9, 1'b0);
    step(1);
    checkOutput("wait_10", 1'b1, 1'b1, 4'd10, 1'b1);
    step(5);
    checkOutput("wait_15", 1'b1, 1'b1, 4'd15, 1'b1);
    step(2);
    checkOutput("wait_sat", 1'b1, 1'b1, 4'd15, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1);
    checkOutput("starve_ack", 1'b0, 1'b0, 4'd15, 1'b0);

    // Reset mid-REQUEST drops vehicle on the following edge
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1);
    checkOutput("idle_again", 1'b0, 1'b0, 4'd15, 1'b0);
    step(4);
    checkOutput("request_again", 1'b1, 1'b1, 4'd0, 1'b0);
    step(2);
    checkOutput("request_wait2", 1'b1, 1'b1, 4'd2, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1);
    checkOutput("reset_request", 1'b0, 1'b0, 4'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_vehicle_detector

// File: doc/vehicle_detector.md
# vehicle_detector

Front end for the highway/country traffic controller. Turns the raw country-road inductive-loop sensor into the controller's `vehicle` request. The raw input is synchronised, debounced and latched until the controller shows country green. The block watches the controller's country light outputs (`gc`, `rc`) as acknowledge, so a request is held across sensor dropout and withdrawn only once served. An optional starvation monitor flags requests left unserved too long.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronised high samples needed to qualify a vehicle; legal range 2..255.
- `WAIT_W`, default 16: width of the wait counter.
- `STARVE_LIMIT`, default 1000: wait cycles at which `starve` asserts; must be < 2^WAIT_W.
- `clk` in 1: single system clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `sys_en` in 1: system enable; 0 forces idle.
- `loop_raw` in 1: asynchronous raw loop sensor; 1 means metal present.
- `gc` in 1: controller green-country output, used as acknowledge.
- `rc` in 1: controller red-country output.
- `vehicle` out 1: registered request to the controller.
- `waiting` out 1: 1 while in REQUEST.
- `wait_count` out WAIT_W: cycles spent in the current or most recent REQUEST.
- `starve` out 1: starvation flag; exists only with the macro.

## Operation
- `loop_raw` passes through a 2-flop synchroniser. Its output is `loop_s`; all FSM decisions use `loop_s`.
- The FSM has four states: IDLE, QUALIFY, REQUEST, SERVED. It also has a debounce counter `db_cnt` (8 bit).
- IDLE:
  - `vehicle`=0.
  - If `loop_s`=1: go to QUALIFY with `db_cnt`=1.
- QUALIFY:
  - If `loop_s`=0: go to IDLE and clear `db_cnt`.
  - Else if `db_cnt`==DEBOUNCE_CYCLES-1: go to REQUEST.
  - Else: `db_cnt`++.
- REQUEST:
  - `vehicle`=1 and `waiting`=1. The request stays latched even if `loop_s` drops.
  - If `gc`=1: go to SERVED.
- SERVED:
  - `vehicle`=0.
  - If `gc`=0 and `rc`=1: go to IDLE. A car still present then re-qualifies from scratch.
- `wait_count`:
  - Cleared on the cycle REQUEST is entered.
  - Increments every cycle in REQUEST and saturates at 2^WAIT_W-1 (no wrap).
  - Holds its value in SERVED and IDLE until the next REQUEST entry.
- `sys_en`=0 on any edge:
  - Next state is IDLE; `db_cnt`, `wait_count` and `starve` are cleared; `vehicle`=0.
  - The synchroniser keeps running.
  - This has priority over every other transition.
- Simultaneous events:
  - `sys_en`=0 with `gc`=1 in REQUEST: go to IDLE.
  - REQUEST entered while `gc` is already 1: SERVED on the next edge, so `vehicle` is high for exactly one cycle.
  - `gc` in IDLE or QUALIFY is ignored.

## Timing
- All outputs are registered.
- Reset values: `vehicle`=0, `waiting`=0, `wait_count`=0, `starve`=0, state IDLE, synchroniser flops 0.
- `reset_n` low mid-REQUEST drops `vehicle` on the following edge.
- Detection latency:
  - With `loop_raw` stable high before edge 1, `loop_s` is 1 after edge 2.
  - `vehicle` rises after edge 2+DEBOUNCE_CYCLES, i.e. edge 6 at the default.
- Glitch rejection: a `loop_s` high run shorter than DEBOUNCE_CYCLES never asserts `vehicle`.
- Release latency: `vehicle` falls on the first edge where `gc`=1 is sampled in REQUEST.

## Configuration
- Macro: `VEHICLE_DET_STARVE_EN`.
- Defined:
  - The `starve` port exists.
  - It rises on the edge where `wait_count` reaches STARVE_LIMIT while in REQUEST.
  - It stays high until REQUEST is left or `sys_en`=0.
- Undefined:
  - No `starve` port and no comparator logic.
  - `wait_count` and `waiting` are unchanged.

## Structure
- Package `vehicle_det_pkg` holds:
  - the state enum `vdet_state_t` (IDLE, QUALIFY, REQUEST, SERVED, 2-bit encoding);
  - default constants `VDET_DEBOUNCE_DEF`, `VDET_WAIT_W_DEF`, `VDET_STARVE_DEF`.
- One sub-module: `sync_2ff`, a generic 2-flop synchroniser with synchronous active-low reset, instantiated for `loop_raw`.

## Test plan
- Clean arrival, DEBOUNCE_CYCLES=4: `loop_raw` 0→1 held. Expect `vehicle`=1 after edge 6, `waiting`=1, and `wait_count` counting 1,2,3…
- Glitch: `loop_raw` high for 3 cycles, then low. Expect `vehicle` to stay 0 and the FSM to return to IDLE.
- Acknowledge: in REQUEST, drive `gc`=1 and `rc`=0 for 5 cycles, then `gc`=0 and `rc`=1. Expect `vehicle` to fall on the first `gc` edge and the FSM to reach IDLE after `rc`=1. With `loop_raw` still 1, `vehicle` re-asserts 4+1 edges later.
- Sensor dropout: `loop_raw` goes 0 while in REQUEST. Expect `vehicle` to stay 1 until `gc`=1.
- Disable and reset: `sys_en`=0 mid-REQUEST on the same edge as `gc`=1. Expect IDLE, `vehicle`=0, `wait_count`=0. Then `reset_n`=0 mid-QUALIFY. Expect all outputs 0 on the next edge.
- Starvation (macro on), WAIT_W=4, STARVE_LIMIT=10: hold REQUEST without `gc`. Expect `starve`=1 when `wait_count`=10, `wait_count` saturating at 15, and `starve` clearing on the `gc` acknowledge.
